// File: rtl/multi_way_blockram_if.sv
// multi_way_blockram_if
// Request/response bundle for the multi-way block RAM: one read port, one
// write port with evict readback, and the init-done indication.
//   master : drives read/write requests, receives read data, evict data, init done
//   slave  : the RAM itself
// Parameters:
//   SET_PTR_WIDTH_IN_BITS : set address width
//   SET_WIDTH_IN_BITS     : width of a full set (NUMBER_WAY * element width)
interface multi_way_blockram_if #(
  parameter int SET_PTR_WIDTH_IN_BITS = 6,
  parameter int SET_WIDTH_IN_BITS     = 128
);
  localparam int BYTE_EN_WIDTH = SET_WIDTH_IN_BITS / 8;

  logic                             read_en_in;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] read_set_addr_in;
  logic [SET_WIDTH_IN_BITS-1:0]     read_set_out;
  logic                             read_valid_out;

  logic                             write_en_in;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] write_set_addr_in;
  logic [SET_WIDTH_IN_BITS-1:0]     write_set_in;
  logic [BYTE_EN_WIDTH-1:0]         write_byte_en_in;
  logic [SET_WIDTH_IN_BITS-1:0]     evict_set_out;
  logic                             evict_valid_out;

  logic                             init_done_out;

  modport master (
    output read_en_in, read_set_addr_in,
    input  read_set_out, read_valid_out,
    output write_en_in, write_set_addr_in, write_set_in, write_byte_en_in,
    input  evict_set_out, evict_valid_out,
    input  init_done_out
  );

  modport slave (
    input  read_en_in, read_set_addr_in,
    output read_set_out, read_valid_out,
    input  write_en_in, write_set_addr_in, write_set_in, write_byte_en_in,
    output evict_set_out, evict_valid_out,
    output init_done_out
  );
endinterface

// File: rtl/multi_way_blockram.sv
// multi_way_blockram
// Block RAM holding NUMBER_WAY elements per set for cache tag/data arrays.
// One read port (1-cycle registered read), one write port with per-byte
// enables and evict readback of the pre-write set, and a hardware sweep that
// zeroes every set after reset before requests are accepted.
// Ports:
//   clk_in     : clock, all logic on the rising edge
//   reset_n_in : asynchronous active-low reset
//   bus        : slave side of multi_way_blockram_if
//                read_en_in/read_set_addr_in -> read_set_out/read_valid_out
//                write_en_in/write_set_addr_in/write_set_in/write_byte_en_in
//                  -> evict_set_out/evict_valid_out
//                init_done_out : array initialised, requests accepted
module multi_way_blockram #(
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
  parameter int NUMBER_WAY                  = 2,
  parameter int NUMBER_SET                  = 64,
  parameter int SET_PTR_WIDTH_IN_BITS       = 6,
  parameter int WRITE_FIRST                 = 0
) (
  input logic                 clk_in,
  input logic                 reset_n_in,
  multi_way_blockram_if.slave bus
);

  localparam int SW = NUMBER_WAY * SINGLE_ELEMENT_SIZE_IN_BITS;
  localparam int BE = SW / 8;
  localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET =
    SET_PTR_WIDTH_IN_BITS'(NUMBER_SET - 1);

  typedef enum logic [0:0] {
    INIT,
    READY
  } state_t;

  state_t                           state_q;
  state_t                           state_d;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] init_ptr_q;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] init_ptr_d;

  logic [SW-1:0] mem [NUMBER_SET];

  logic                             ram_we;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] ram_waddr;
  logic [SW-1:0]                    ram_wdata;
  logic [BE-1:0]                    ram_be;

  logic          ready;
  logic          rd_fire;
  logic          wr_fire;
  logic [SW-1:0] rd_old;
  logic [SW-1:0] wr_old;
  logic [SW-1:0] rd_merged;
  logic [SW-1:0] rd_data;

  // State register and init sweep pointer.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  // INIT walks every set once; the last set is written in the same cycle the
  // FSM decides to move to READY, so INIT lasts exactly NUMBER_SET cycles.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    case (state_q)
      INIT: begin
        init_ptr_d = init_ptr_q + SET_PTR_WIDTH_IN_BITS'(1);
        if (init_ptr_q == LAST_SET) begin
          state_d    = READY;
          init_ptr_d = '0;
        end
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  assign ready   = (state_q == READY);
  assign rd_fire = ready && bus.read_en_in;
  assign wr_fire = ready && bus.write_en_in;

  // Single array write port shared between the init sweep and user writes.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = bus.write_set_addr_in;
    ram_wdata = bus.write_set_in;
    ram_be    = bus.write_byte_en_in;
    if (!ready) begin
      ram_we    = 1'b1;
      ram_waddr = init_ptr_q;
      ram_wdata = '0;
      ram_be    = '1;
    end else if (bus.write_en_in) begin
      ram_we = 1'b1;
    end
  end

  // Byte-enabled array write; storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk_in) begin
    for (int b = 0; b < BE; b++) begin
      if (ram_we && ram_be[b]) begin
        mem[ram_waddr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end
    end
  end

  assign rd_old = mem[bus.read_set_addr_in];
  assign wr_old = mem[bus.write_set_addr_in];

  // Write-first bypass: on a same-set collision overlay the enabled write
  // bytes onto the old read data. Read-first simply uses the old data.
  always_comb begin
    rd_merged = rd_old;
    if (wr_fire && (bus.write_set_addr_in == bus.read_set_addr_in)) begin
      for (int b = 0; b < BE; b++) begin
        if (bus.write_byte_en_in[b]) begin
          rd_merged[b*8 +: 8] = bus.write_set_in[b*8 +: 8];
        end
      end
    end
  end

  assign rd_data = (WRITE_FIRST != 0) ? rd_merged : rd_old;

  // Output registers: data holds between requests, valids pulse for one cycle.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      bus.read_set_out    <= '0;
      bus.read_valid_out  <= 1'b0;
      bus.evict_set_out   <= '0;
      bus.evict_valid_out <= 1'b0;
    end else begin
      bus.read_valid_out  <= rd_fire;
      bus.evict_valid_out <= wr_fire;
      if (rd_fire) begin
        bus.read_set_out <= rd_data;
      end
      if (wr_fire) begin
        bus.evict_set_out <= wr_old;
      end
    end
  end

  assign bus.init_done_out = ready;

endmodule

// File: tb/tb_multi_way_blockram.sv
// tb_multi_way_blockram
// Directed bench for multi_way_blockram. Two instances share one stimulus:
// dut0 in read-first collision mode, dut1 in write-first mode.
module tb_multi_way_blockram;

  localparam int P  = 6;
  localparam int NS = 64;
  localparam int SW = 128;
  localparam int BE = 16;

  localparam logic [SW-1:0] D1 = {64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444};
  localparam logic [SW-1:0] D2 = {64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_FFFF};
  localparam logic [SW-1:0] D3 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [SW-1:0] D9 = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
  localparam logic [SW-1:0] ONES = '1;
  localparam logic [SW-1:0] ZERO = '0;

  logic clk_in = 1'b0;
  logic reset_n_in;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk_in = ~clk_in;

  multi_way_blockram_if #(.SET_PTR_WIDTH_IN_BITS(P), .SET_WIDTH_IN_BITS(SW)) bus0 ();
  multi_way_blockram_if #(.SET_PTR_WIDTH_IN_BITS(P), .SET_WIDTH_IN_BITS(SW)) bus1 ();

  // dut1 sees exactly the stimulus driven on bus0.
  assign bus1.read_en_in        = bus0.read_en_in;
  assign bus1.read_set_addr_in  = bus0.read_set_addr_in;
  assign bus1.write_en_in       = bus0.write_en_in;
  assign bus1.write_set_addr_in = bus0.write_set_addr_in;
  assign bus1.write_set_in      = bus0.write_set_in;
  assign bus1.write_byte_en_in  = bus0.write_byte_en_in;

  multi_way_blockram #(.WRITE_FIRST(0)) dut0 (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .bus        (bus0)
  );

  multi_way_blockram #(.WRITE_FIRST(1)) dut1 (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .bus        (bus1)
  );

  // One comparison: counts it and reports tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input logic [SW-1:0] observed,
                             input logic [SW-1:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives one request cycle, returns #1 after the capturing edge with enables dropped.
  task automatic applyStimulus(input logic re, input logic [P-1:0] raddr,
                               input logic we, input logic [P-1:0] waddr,
                               input logic [SW-1:0] wdata, input logic [BE-1:0] be);
    if (int'(raddr) >= NS || int'(waddr) >= NS) begin
      failCount++;
      $display("[TB] FAIL addr_range raddr=%0d waddr=%0d limit=%0d", raddr, waddr, NS);
    end
    bus0.read_en_in        = re;
    bus0.read_set_addr_in  = raddr;
    bus0.write_en_in       = we;
    bus0.write_set_addr_in = waddr;
    bus0.write_set_in      = wdata;
    bus0.write_byte_en_in  = be;
    @(posedge clk_in);
    #1;
    bus0.read_en_in  = 1'b0;
    bus0.write_en_in = 1'b0;
  endtask

  // Counts edges until init_done rises (bounded), watching for stray read valids.
  task automatic waitInit(input string tag);
    int  cycles;
    logic sawValid;
    cycles   = 0;
    sawValid = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk_in);
      #1;
      if (bus0.read_valid_out || bus1.read_valid_out) sawValid = 1'b1;
      if (bus0.init_done_out) begin
        cycles = i;
        break;
      end
    end
    checkOutput({tag, "_init_cycles"}, SW'(cycles), SW'(64));
    checkOutput({tag, "_no_read_valid"}, SW'(sawValid), ZERO);
    checkOutput({tag, "_init_done1"}, SW'(bus1.init_done_out), SW'(1));
  endtask

  // Read one set on both instances and compare data and valid.
  task automatic readCheck(input string tag, input logic [P-1:0] addr,
                           input logic [SW-1:0] expected);
    applyStimulus(1'b1, addr, 1'b0, '0, ZERO, '0);
    checkOutput({tag, "_valid"}, SW'(bus0.read_valid_out), SW'(1));
    checkOutput({tag, "_data0"}, bus0.read_set_out, expected);
    checkOutput({tag, "_data1"}, bus1.read_set_out, expected);
  endtask

  initial begin
    reset_n_in             = 1'b0;
    bus0.read_en_in        = 1'b0;
    bus0.read_set_addr_in  = '0;
    bus0.write_en_in       = 1'b0;
    bus0.write_set_addr_in = '0;
    bus0.write_set_in      = '0;
    bus0.write_byte_en_in  = '0;
    repeat (2) @(posedge clk_in);
    #1;

    // Reset state
    checkOutput("rst_read_valid", SW'(bus0.read_valid_out), ZERO);
    checkOutput("rst_evict_valid", SW'(bus0.evict_valid_out), ZERO);
    checkOutput("rst_init_done", SW'(bus0.init_done_out), ZERO);
    checkOutput("rst_read_data", bus0.read_set_out, ZERO);
    checkOutput("rst_evict_data", bus0.evict_set_out, ZERO);

    // Init sweep with read requested throughout
    bus0.read_en_in = 1'b1;
    reset_n_in      = 1'b1;
    waitInit("init");
    bus0.read_en_in = 1'b0;

    readCheck("rd_set0", 6'd0, ZERO);
    readCheck("rd_set31", 6'd31, ZERO);
    readCheck("rd_set63", 6'd63, ZERO);

    // Full write then read
    applyStimulus(1'b0, '0, 1'b1, 6'd5, D1, 16'hFFFF);
    checkOutput("wr5_evict_valid", SW'(bus0.evict_valid_out), SW'(1));
    checkOutput("wr5_evict", bus0.evict_set_out, ZERO);
    readCheck("rd5_full", 6'd5, D1);

    // Idle: valids drop, read data held
    applyStimulus(1'b0, '0, 1'b0, '0, ZERO, '0);
    checkOutput("idle_read_valid", SW'(bus0.read_valid_out), ZERO);
    checkOutput("idle_evict_valid", SW'(bus0.evict_valid_out), ZERO);
    checkOutput("idle_read_hold", bus0.read_set_out, D1);

    // Byte merge on the two lowest bytes
    applyStimulus(1'b0, '0, 1'b1, 6'd5, ONES, 16'h0003);
    checkOutput("merge_evict", bus0.evict_set_out, D1);
    readCheck("rd5_merge", 6'd5, D2);

    // Same-set collision on set 9
    applyStimulus(1'b1, 6'd9, 1'b1, 6'd9, ONES, 16'h00FF);
    checkOutput("coll_rd_wf0", bus0.read_set_out, ZERO);
    checkOutput("coll_rd_eq_evict_wf0", bus0.read_set_out, bus0.evict_set_out === ZERO ? ZERO : ONES);
    checkOutput("coll_rd_wf1", bus1.read_set_out, D9);
    checkOutput("coll_evict_wf1", bus1.evict_set_out, ZERO);
    checkOutput("coll_valid_wf1", SW'(bus1.read_valid_out), SW'(1));
    readCheck("rd9_after_coll", 6'd9, D9);

    // Back-to-back write then read of the same set
    applyStimulus(1'b0, '0, 1'b1, 6'd12, D3, 16'hFFFF);
    readCheck("rd12_b2b", 6'd12, D3);

    // Read and write of different sets in the same cycle
    applyStimulus(1'b1, 6'd5, 1'b1, 6'd20, D1, 16'hFFFF);
    checkOutput("indep_rd", bus0.read_set_out, D2);
    checkOutput("indep_evict_valid", SW'(bus0.evict_valid_out), SW'(1));
    checkOutput("indep_evict", bus0.evict_set_out, ZERO);
    readCheck("rd20", 6'd20, D1);

    // Probe write with no bytes enabled
    applyStimulus(1'b0, '0, 1'b1, 6'd5, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF, 16'h0000);
    checkOutput("probe_evict_valid", SW'(bus0.evict_valid_out), SW'(1));
    checkOutput("probe_evict", bus0.evict_set_out, D2);
    readCheck("rd5_probe", 6'd5, D2);

    // Reset in the middle of a read/write burst
    bus0.read_en_in        = 1'b1;
    bus0.read_set_addr_in  = 6'd12;
    bus0.write_en_in       = 1'b1;
    bus0.write_set_addr_in = 6'd30;
    bus0.write_set_in      = D1;
    bus0.write_byte_en_in  = 16'hFFFF;
    @(posedge clk_in);
    #1;
    checkOutput("burst_read_valid", SW'(bus0.read_valid_out), SW'(1));
    checkOutput("burst_evict_valid", SW'(bus0.evict_valid_out), SW'(1));
    #2;
    reset_n_in = 1'b0;
    #1;
    checkOutput("midrst_read_valid", SW'(bus0.read_valid_out), ZERO);
    checkOutput("midrst_evict_valid", SW'(bus0.evict_valid_out), ZERO);
    checkOutput("midrst_read_data", bus0.read_set_out, ZERO);
    checkOutput("midrst_evict_data", bus1.evict_set_out, ZERO);
    checkOutput("midrst_init_done", SW'(bus0.init_done_out), ZERO);
    bus0.read_en_in  = 1'b0;
    bus0.write_en_in = 1'b0;
    @(posedge clk_in);
    #1;
    reset_n_in = 1'b1;
    waitInit("reinit");

    readCheck("rd5_reinit", 6'd5, ZERO);
    readCheck("rd9_reinit", 6'd9, ZERO);
    readCheck("rd12_reinit", 6'd12, ZERO);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
